// File: rtl/instr_mem_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : instr_mem_pipe
//  Purpose  : Word-organised instruction memory with a valid/ready fetch
//             handshake and a fixed, parameterised access latency. Misaligned
//             and out-of-range fetches are reported as faults and return 0.
//             A separate load port writes words at any time, independent of
//             the fetch state machine.
//  Ports    :
//     clk        in   rising-edge clock
//     rst        in   asynchronous active-low reset
//     req_valid  in   fetch request valid
//     req_ready  out  block can accept a request (IDLE only)
//     req_addr   in   byte address of the fetch
//     rsp_valid  out  response valid (RESP only)
//     rsp_ready  in   consumer accepts the response
//     rsp_data   out  fetched word, 0 on fault
//     rsp_fault  out  bit0 misaligned, bit1 out of range
//     ld_en      in   load-port write enable
//     ld_addr    in   load-port word index
//     ld_data    in   load-port write data
//     busy       out  high whenever the state machine is not IDLE
//  Revision : 1.0  initial release
// ============================================================================
module instr_mem_pipe #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [ADDR_W-1:0]        req_addr,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [DATA_W-1:0]        rsp_data,
   output logic [1:0]               rsp_fault,
   input  logic                     ld_en,
   input  logic [$clog2(DEPTH)-1:0] ld_addr,
   input  logic [DATA_W-1:0]        ld_data,
   output logic                     busy
);

   localparam int         c_idx_w   = $clog2(DEPTH);
   localparam logic [3:0] c_wait_ld = 4'(WAIT_CYCLES);

   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_wait = 2'd1;
   localparam logic [1:0] c_st_resp = 2'd2;

   logic [1:0]          r_state;
   logic [1:0]          w_state_nxt;
   logic [3:0]          r_cnt;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_rsp_data;
   logic [1:0]          r_rsp_fault;
   logic [DATA_W-1:0]   mem [DEPTH];

   logic                w_accept;
   logic                w_enter_resp;
   logic [ADDR_W-1:0]   w_rd_addr;
   logic [c_idx_w-1:0]  w_idx;
   logic                w_misalign;
   logic                w_oor;

   assign w_accept     = req_valid && (r_state == c_st_idle);
   assign w_enter_resp = (w_state_nxt == c_st_resp) && (r_state != c_st_resp);

   // With zero wait states the read happens on the accept edge itself, before
   // the address has been latched, so the live request address is used then.
   assign w_rd_addr  = (r_state == c_st_idle) ? req_addr : r_addr;
   assign w_idx      = w_rd_addr[c_idx_w+1:2];
   assign w_misalign = |w_rd_addr[1:0];

   // Address bits above the word index only matter for the range check.
   generate
      if (ADDR_W > c_idx_w + 2) begin : g_oor_chk
         assign w_oor = |w_rd_addr[ADDR_W-1:c_idx_w+2];
      end else begin : g_oor_none
         assign w_oor = 1'b0;
      end
   endgenerate

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle: begin
            if (req_valid) begin
               w_state_nxt = (c_wait_ld == 4'd0) ? c_st_resp : c_st_wait;
            end
         end
         c_st_wait: begin
            if (r_cnt == 4'd1) begin
               w_state_nxt = c_st_resp;
            end
         end
         c_st_resp: begin
            if (rsp_ready) begin
               w_state_nxt = c_st_idle;
            end
         end
         default: w_state_nxt = c_st_idle;
      endcase
   end

   // ------------------------------------------------------------------------
   // Output decode
   // ------------------------------------------------------------------------
   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      busy      = 1'b1;
      case (r_state)
         c_st_idle: begin
            req_ready = 1'b1;
            busy      = 1'b0;
         end
         c_st_resp: rsp_valid = 1'b1;
         default:   ;
      endcase
   end

   // ------------------------------------------------------------------------
   // Fetch datapath: latched address, wait counter, response registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_addr      <= '0;
         r_cnt       <= '0;
         r_rsp_data  <= '0;
         r_rsp_fault <= '0;
      end else begin
         if (w_accept) begin
            r_addr <= req_addr;
            r_cnt  <= c_wait_ld;
         end else if (r_state == c_st_wait) begin
            r_cnt <= r_cnt - 4'd1;
         end

         // Sampling here with a non-blocking read gives old data when the
         // load port writes the same word on the same edge.
         if (w_enter_resp) begin
            r_rsp_fault <= {w_oor, w_misalign};
            if (w_oor || w_misalign) begin
               r_rsp_data <= '0;
            end else begin
               r_rsp_data <= mem[w_idx];
            end
         end
      end
   end

   assign rsp_data  = r_rsp_data;
   assign rsp_fault = r_rsp_fault;

   // ------------------------------------------------------------------------
   // Load port: contents survive reset, so no reset term here.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (ld_en) begin
         mem[ld_addr] <= ld_data;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_mem_pipe
//  Purpose  : Directed self-checking bench. Two instances share all inputs:
//             one with zero wait states and one with three, so every fetch
//             exercises both latencies at once.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_mem_pipe;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        rsp_ready;
   logic        ld_en;
   logic [9:0]  ld_addr;
   logic [31:0] ld_data;

   logic        req_ready0, rsp_valid0, busy0;
   logic [31:0] rsp_data0;
   logic [1:0]  rsp_fault0;
   logic        req_ready3, rsp_valid3, busy3;
   logic [31:0] rsp_data3;
   logic [1:0]  rsp_fault3;

   int total;
   int bad;

   instr_mem_pipe #(.ADDR_W(32), .DATA_W(32), .DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .rst(rst_n),
      .req_valid(req_valid), .req_ready(req_ready0), .req_addr(req_addr),
      .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_data(rsp_data0),
      .rsp_fault(rsp_fault0), .ld_en(ld_en), .ld_addr(ld_addr),
      .ld_data(ld_data), .busy(busy0)
   );

   instr_mem_pipe #(.ADDR_W(32), .DATA_W(32), .DEPTH(1024), .WAIT_CYCLES(3)) u_dut3 (
      .clk(clk), .rst(rst_n),
      .req_valid(req_valid), .req_ready(req_ready3), .req_addr(req_addr),
      .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_data(rsp_data3),
      .rsp_fault(rsp_fault3), .ld_en(ld_en), .ld_addr(ld_addr),
      .ld_data(ld_data), .busy(busy3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [9:0] a, input logic [31:0] d);
      ld_en   = 1'b1;
      ld_addr = a;
      ld_data = d;
      @(posedge clk); #1;
      ld_en   = 1'b0;
   endtask

   // One request accepted on edge 0. Latency is the number of edges, counting
   // the accept edge, after which rsp_valid is seen. ld_at selects the edge on
   // which the load port writes 'ldv' to word 2 (-1 for none).
   task automatic fetch(input logic [31:0] addr, input int ld_at, input logic [31:0] ldv,
                        output logic [31:0] d0, output logic [1:0] f0, output int l0,
                        output logic [31:0] d3, output logic [1:0] f3, output int l3,
                        output logic wait_ok);
      bit g0, g3;
      g0 = 0; g3 = 0; l0 = -1; l3 = -1;
      d0 = 'x; f0 = 'x; d3 = 'x; f3 = 'x; wait_ok = 1'b1;
      req_valid = 1'b1;
      req_addr  = addr;
      rsp_ready = 1'b1;
      for (int n = 0; n < 20 && !(g0 && g3); n++) begin
         ld_en   = (n == ld_at);
         ld_addr = 10'd2;
         ld_data = ldv;
         @(posedge clk); #1;
         req_valid = 1'b0;
         if (!g0 && rsp_valid0) begin
            g0 = 1; d0 = rsp_data0; f0 = rsp_fault0; l0 = n + 1;
         end
         if (!g3) begin
            if (busy3 !== 1'b1 || req_ready3 !== 1'b0) wait_ok = 1'b0;
            if (rsp_valid3) begin
               g3 = 1; d3 = rsp_data3; f3 = rsp_fault3; l3 = n + 1;
            end
         end
      end
      ld_en = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic run(input string tag, input logic [31:0] addr, input int ld_at,
                      input logic [31:0] ldv, input logic [31:0] exp0,
                      input logic [31:0] exp3, input logic [1:0] expf);
      logic [31:0] d0, d3;
      logic [1:0]  f0, f3;
      int          l0, l3;
      logic        wok;
      fetch(addr, ld_at, ldv, d0, f0, l0, d3, f3, l3, wok);
      chk({tag, ".w0.data"}, d0, exp0);
      chk({tag, ".w0.fault"}, 32'(f0), 32'(expf));
      chk({tag, ".w0.lat"}, 32'(l0), 32'd1);
      chk({tag, ".w3.data"}, d3, exp3);
      chk({tag, ".w3.fault"}, 32'(f3), 32'(expf));
      chk({tag, ".w3.lat"}, 32'(l3), 32'd4);
      chk({tag, ".w3.busy_noready"}, 32'(wok), 32'd1);
   endtask

   initial begin
      logic st0, st3, quiet;
      total = 0; bad = 0;
      rsp_n_init();

      // Reset values
      #3;
      chk("rst.req_ready0", 32'(req_ready0), 32'd1);
      chk("rst.req_ready3", 32'(req_ready3), 32'd1);
      chk("rst.rsp_valid0", 32'(rsp_valid0), 32'd0);
      chk("rst.rsp_valid3", 32'(rsp_valid3), 32'd0);
      chk("rst.busy3", 32'(busy3), 32'd0);
      chk("rst.data0", rsp_data0, 32'd0);
      chk("rst.fault3", 32'(rsp_fault3), 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;

      load(10'd0, 32'h0064A423);
      load(10'd1, 32'hFFC4A303);
      load(10'd2, 32'h00000013);

      // Normal fetches and faults
      run("f0",     32'h0000_0000, -1, 32'h0, 32'h0064A423, 32'h0064A423, 2'b00);
      run("f4",     32'h0000_0004, -1, 32'h0, 32'hFFC4A303, 32'hFFC4A303, 2'b00);
      run("mis6",   32'h0000_0006, -1, 32'h0, 32'h0, 32'h0, 2'b01);
      run("oor1000",32'h0000_1000, -1, 32'h0, 32'h0, 32'h0, 2'b10);
      run("both1002",32'h0000_1002,-1, 32'h0, 32'h0, 32'h0, 2'b11);

      // Load collides with the read edge: wait-0 reads on edge 0, wait-3 on edge 3
      run("col_e0", 32'h0000_0008, 0, 32'hDEADBEEF, 32'h00000013, 32'hDEADBEEF, 2'b00);
      load(10'd2, 32'h00000013);
      run("col_e3", 32'h0000_0008, 3, 32'hDEADBEEF, 32'h00000013, 32'h00000013, 2'b00);
      run("after",  32'h0000_0008, -1, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00);

      // Backpressure: hold rsp_ready low, wiggle request inputs
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_addr  = 32'h0000_0004;
      @(posedge clk); #1;
      repeat (3) begin
         req_addr = 32'h0000_1002;
         @(posedge clk); #1;
      end
      st0 = 1'b1; st3 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         req_addr = (i % 2 == 0) ? 32'h0000_0006 : 32'h0000_0000;
         @(posedge clk); #1;
         if (rsp_valid0 !== 1'b1 || rsp_data0 !== 32'hFFC4A303 || rsp_fault0 !== 2'b00) st0 = 1'b0;
         if (rsp_valid3 !== 1'b1 || rsp_data3 !== 32'hFFC4A303 || rsp_fault3 !== 2'b00) st3 = 1'b0;
      end
      chk("bp.stable0", 32'(st0), 32'd1);
      chk("bp.stable3", 32'(st3), 32'd1);
      chk("bp.ready_low0", 32'(req_ready0), 32'd0);
      rsp_ready = 1'b1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      chk("bp.idle0", 32'(req_ready0), 32'd1);
      chk("bp.idle3", 32'(req_ready3), 32'd1);
      chk("bp.drop3", 32'(rsp_valid3), 32'd0);

      // Asynchronous reset while the wait-3 instance is in WAIT
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_addr  = 32'h0000_0004;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      chk("ar.pre_data0", rsp_data0, 32'hFFC4A303);
      chk("ar.pre_busy3", 32'(busy3), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar.rsp_valid0", 32'(rsp_valid0), 32'd0);
      chk("ar.data0", rsp_data0, 32'd0);
      chk("ar.busy3", 32'(busy3), 32'd0);
      chk("ar.req_ready3", 32'(req_ready3), 32'd1);
      chk("ar.fault3", 32'(rsp_fault3), 32'd0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      quiet = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (rsp_valid0 !== 1'b0 || rsp_valid3 !== 1'b0) quiet = 1'b0;
      end
      chk("ar.no_response", 32'(quiet), 32'd1);
      run("ar.mem_kept", 32'h0000_0000, -1, 32'h0, 32'h0064A423, 32'h0064A423, 2'b00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   task automatic rsp_n_init();
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_addr  = '0;
      rsp_ready = 1'b0;
      ld_en     = 1'b0;
      ld_addr   = '0;
      ld_data   = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
